wb_interconnect_nxm: RTL and testbench

- Parametrised Wishbone classic crossbar, successor to the fixed 2x2 interconnect.
- Connects N_MASTERS initiators to N_SLAVES targets. Each slave has its own address window and its own round-robin arbiter.
- Unmapped addresses get an error response from an internal default slave.
- Sits between BFMs/CPUs and peripheral subsystems or SRAM in the subsystem testbenches and SoC tops.

---
 rtl/wb_interconnect_nxm.sv | 209 ++++++++++++++++++++
 tb/tb_wb_interconnect_nxm.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_interconnect_nxm.sv
// N-master x M-slave Wishbone classic crossbar: per-slave address windows, per-slave round-robin
// arbitration with bus lock while cyc is held, internal error slave. Optional watchdog: WB_IC_TIMEOUT_EN.
module wb_interconnect_nxm #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int N_MASTERS     = 2,
    parameter int N_SLAVES      = 2,
    parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_BASE  = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_LIMIT = {N_SLAVES{32'hFFFF_FFFF}}
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]     m_adr,
    input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_dat_w,
    output logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_dat_r,
    input  logic [N_MASTERS-1:0]                   m_cyc,
    input  logic [N_MASTERS-1:0]                   m_stb,
    input  logic [N_MASTERS-1:0]                   m_we,
    input  logic [N_MASTERS*WB_DATA_WIDTH/8-1:0]   m_sel,
    output logic [N_MASTERS-1:0]                   m_ack,
    output logic [N_MASTERS-1:0]                   m_err,
    output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]      s_adr,
    output logic [N_SLAVES*WB_DATA_WIDTH-1:0]      s_dat_w,
    input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]      s_dat_r,
    output logic [N_SLAVES-1:0]                    s_cyc,
    output logic [N_SLAVES-1:0]                    s_stb,
    output logic [N_SLAVES-1:0]                    s_we,
    output logic [N_SLAVES*WB_DATA_WIDTH/8-1:0]    s_sel,
    input  logic [N_SLAVES-1:0]                    s_ack,
    input  logic [N_SLAVES-1:0]                    s_err
);

    localparam int AW  = WB_ADDR_WIDTH;
    localparam int DW  = WB_DATA_WIDTH;
    localparam int SW  = DW / 8;
    localparam int NT  = N_SLAVES + 1;  // index N_SLAVES is the error slave
    localparam int MIW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int TIW = $clog2(NT);

    logic [AW-1:0]        m_adr_a   [N_MASTERS];
    logic [DW-1:0]        m_dat_w_a [N_MASTERS];
    logic [SW-1:0]        m_sel_a   [N_MASTERS];
    logic [TIW-1:0]       tgt       [N_MASTERS];
    logic [N_MASTERS-1:0] busy;
    logic [N_MASTERS-1:0] req       [NT];

    logic [NT-1:0]        gnt_q, gnt_d;
    logic [MIW-1:0]       own_q [NT];
    logic [MIW-1:0]       own_d [NT];
    logic [MIW-1:0]       rr_q  [NT];
    logic [MIW-1:0]       rr_d  [NT];
    logic                 err_q, err_d;

    logic [N_SLAVES-1:0]  raw_stb;
    logic [N_SLAVES-1:0]  to_fire;

    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
            assign m_adr_a[gi]   = m_adr[gi*AW +: AW];
            assign m_dat_w_a[gi] = m_dat_w[gi*DW +: DW];
            assign m_sel_a[gi]   = m_sel[gi*SW +: SW];
        end
    endgenerate

    // Descending scan so the lowest-indexed matching window wins on overlap.
    always_comb begin
        for (int m = 0; m < N_MASTERS; m++) begin
            tgt[m] = TIW'(N_SLAVES);
            for (int i = N_SLAVES - 1; i >= 0; i--) begin
                if (m_adr_a[m] >= SLAVE_ADDR_BASE[i*AW +: AW] &&
                    m_adr_a[m] <= SLAVE_ADDR_LIMIT[i*AW +: AW])
                    tgt[m] = TIW'(i);
            end
        end
    end

    // A master that already owns a target (e.g. after an illegal mid-cyc address change)
    // must not also claim a second one.
    always_comb begin
        busy = '0;
        for (int t = 0; t < NT; t++)
            for (int m = 0; m < N_MASTERS; m++)
                if (gnt_q[t] && own_q[t] == MIW'(m))
                    busy[m] = 1'b1;
    end

    always_comb begin
        for (int t = 0; t < NT; t++) begin
            req[t] = '0;
            for (int m = 0; m < N_MASTERS; m++)
                req[t][m] = m_cyc[m] & m_stb[m] & ~busy[m] & (tgt[m] == TIW'(t));
        end
    end

    always_comb begin
        gnt_d = gnt_q;
        for (int t = 0; t < NT; t++) begin
            logic found;
            int   idx;
            found    = 1'b0;
            idx      = 0;
            own_d[t] = own_q[t];
            rr_d[t]  = rr_q[t];
            if (gnt_q[t]) begin
                if (!m_cyc[own_q[t]]) begin
                    gnt_d[t] = 1'b0;
                    rr_d[t]  = (own_q[t] == MIW'(N_MASTERS - 1)) ? '0 : own_q[t] + 1'b1;
                end
            end else begin
                for (int off = 0; off < N_MASTERS; off++) begin
                    idx = (int'(rr_q[t]) + off) % N_MASTERS;
                    if (!found && req[t][idx]) begin
                        found    = 1'b1;
                        gnt_d[t] = 1'b1;
                        own_d[t] = MIW'(idx);
                    end
                end
            end
        end
        // Error slave: err pulses one cycle after a granted stb, then rests one cycle.
        err_d = gnt_q[N_SLAVES] & m_cyc[own_q[N_SLAVES]] & m_stb[own_q[N_SLAVES]] & ~err_q;
    end

    always_comb begin
        raw_stb = '0;
        for (int t = 0; t < N_SLAVES; t++)
            raw_stb[t] = gnt_q[t] & m_stb[own_q[t]];
    end

`ifdef WB_IC_TIMEOUT_EN
    logic [7:0] wd_q [N_SLAVES];
    logic [7:0] wd_d [N_SLAVES];

    always_comb begin
        to_fire = '0;
        for (int t = 0; t < N_SLAVES; t++) begin
            to_fire[t] = raw_stb[t] & ~s_ack[t] & ~s_err[t] & (wd_q[t] == 8'hFF);
            wd_d[t]    = (raw_stb[t] & ~s_ack[t] & ~s_err[t] & (wd_q[t] != 8'hFF))
                         ? wd_q[t] + 8'd1 : 8'd0;
        end
    end
`else
    assign to_fire = '0;
`endif

    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_cyc   = '0;
        s_stb   = '0;
        s_we    = '0;
        for (int t = 0; t < N_SLAVES; t++) begin
            if (gnt_q[t]) begin
                s_cyc[t]             = m_cyc[own_q[t]];
                s_stb[t]             = raw_stb[t] & ~to_fire[t];
                s_we[t]              = m_we[own_q[t]];
                s_adr[t*AW +: AW]    = m_adr_a[own_q[t]];
                s_dat_w[t*DW +: DW]  = m_dat_w_a[own_q[t]];
                s_sel[t*SW +: SW]    = m_sel_a[own_q[t]];
            end
        end
    end

    always_comb begin
        m_ack   = '0;
        m_err   = '0;
        m_dat_r = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            for (int t = 0; t < N_SLAVES; t++) begin
                if (gnt_q[t] && own_q[t] == MIW'(m)) begin
                    m_ack[m]             = s_ack[t];
                    m_err[m]             = s_err[t] | to_fire[t];
                    m_dat_r[m*DW +: DW]  = s_dat_r[t*DW +: DW];
                end
            end
            if (gnt_q[N_SLAVES] && own_q[N_SLAVES] == MIW'(m))
                m_err[m] = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            gnt_q <= '0;
            err_q <= 1'b0;
            for (int t = 0; t < NT; t++) begin
                own_q[t] <= '0;
                rr_q[t]  <= '0;
            end
`ifdef WB_IC_TIMEOUT_EN
            for (int t = 0; t < N_SLAVES; t++)
                wd_q[t] <= 8'd0;
`endif
        end else begin
            gnt_q <= gnt_d;
            err_q <= err_d;
            for (int t = 0; t < NT; t++) begin
                own_q[t] <= own_d[t];
                rr_q[t]  <= rr_d[t];
            end
`ifdef WB_IC_TIMEOUT_EN
            for (int t = 0; t < N_SLAVES; t++)
                wd_q[t] <= wd_d[t];
`endif
        end
    end

endmodule

// File: tb/tb_wb_interconnect_nxm.sv
// Directed bench for wb_interconnect_nxm (2 masters, 2 slaves, error slave, optional watchdog).
module tb_wb_interconnect_nxm;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] m_adr, m_dat_w, m_dat_r;
    logic [1:0]  m_cyc, m_stb, m_we, m_ack, m_err;
    logic [7:0]  m_sel;
    logic [63:0] s_adr, s_dat_w, s_dat_r;
    logic [1:0]  s_cyc, s_stb, s_we, s_ack, s_err;
    logic [7:0]  s_sel;

    int n_cmp = 0;
    int n_mis = 0;
    int got;

    always #5 clk = ~clk;

    wb_interconnect_nxm #(
        .WB_ADDR_WIDTH   (32),
        .WB_DATA_WIDTH   (32),
        .N_MASTERS       (2),
        .N_SLAVES        (2),
        .SLAVE_ADDR_BASE ({32'h1000_0000, 32'h0000_0000}),
        .SLAVE_ADDR_LIMIT({32'h1FFF_FFFF, 32'h0000_1FFF})
    ) dut (
        .clk(clk), .rstn(rstn),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
        .m_ack(m_ack), .m_err(m_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_ack(s_ack), .s_err(s_err)
    );

    // Slave 0: 16-word memory, registered ack. Slave 1: returns A5A5 + low address, can hang.
    logic [31:0] mem0 [16];
    logic        ack0, ack1, hang1;
    logic [31:0] rd0, rd1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ack0 <= 1'b0;
            rd0  <= 32'h0;
        end else if (s_cyc[0] && s_stb[0] && !ack0) begin
            ack0 <= 1'b1;
            if (s_we[0]) mem0[s_adr[5:2]] <= s_dat_w[31:0];
            else         rd0 <= mem0[s_adr[5:2]];
        end else begin
            ack0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ack1 <= 1'b0;
            rd1  <= 32'h0;
        end else if (s_cyc[1] && s_stb[1] && !ack1 && !hang1) begin
            ack1 <= 1'b1;
            rd1  <= {16'hA5A5, s_adr[47:32]};
        end else begin
            ack1 <= 1'b0;
        end
    end

    assign s_ack   = {ack1, ack0};
    assign s_err   = 2'b00;
    assign s_dat_r = {rd1, rd0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rstn = 1'b0; hang1 = 1'b0;
        m_adr = '0; m_dat_w = '0; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
        repeat (3) step();
        #1;
        chk("rst_s_cyc", s_cyc, 2'b00);
        chk("rst_s_stb", s_stb, 2'b00);
        chk("rst_m_ack", m_ack, 2'b00);
        chk("rst_m_err", m_err, 2'b00);
        chk("rst_m_dat_r", m_dat_r, 64'h0);
        chk("rst_s_adr", s_adr, 64'h0);
        rstn = 1'b1;
        step();

        // Single write then read on slave 0
        m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 1; m_adr[31:0] = 32'h0;
        m_dat_w[31:0] = 32'h1234_5678; m_sel[3:0] = 4'hF;
        #1;
        chk("wr_no_stb_yet", s_stb, 2'b00);
        step();
        chk("wr_s_stb", s_stb, 2'b01);
        chk("wr_s_dat_w", s_dat_w[31:0], 32'h1234_5678);
        chk("wr_s_sel", s_sel[3:0], 4'hF);
        chk("wr_s_we", s_we, 2'b01);
        step();
        chk("wr_ack", m_ack, 2'b01);
        m_cyc[0] = 0; m_stb[0] = 0; m_we[0] = 0;
        step();
        m_cyc[0] = 1; m_stb[0] = 1; m_adr[31:0] = 32'h0;
        #1;
        chk("rd_idle", s_stb, 2'b00);
        step();
        chk("rd_s_stb", s_stb, 2'b01);
        step();
        chk("rd_ack", m_ack, 2'b01);
        chk("rd_data", m_dat_r[31:0], 32'h1234_5678);
        m_cyc[0] = 0; m_stb[0] = 0;
        step();
        chk("rd_single_ack", m_ack, 2'b00);

        // Both masters request slave 1 from reset pointer
        m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
        m_adr = {32'h1000_0004, 32'h1000_0000};
        #1;
        chk("arb_no_stb_yet", s_stb, 2'b00);
        step();
        chk("arb_s_stb", s_stb, 2'b10);
        chk("arb_m0_adr", s_adr[63:32], 32'h1000_0000);
        step();
        chk("arb_m0_ack", m_ack, 2'b01);
        chk("arb_m0_dat", m_dat_r, {32'h0, 32'hA5A5_0000});
        m_cyc[0] = 0; m_stb[0] = 0;
        step();
        chk("arb_idle_gap", s_cyc, 2'b00);
        step();
        chk("arb_m1_stb", s_stb, 2'b10);
        chk("arb_m1_adr", s_adr[63:32], 32'h1000_0004);
        step();
        chk("arb_m1_ack", m_ack, 2'b10);
        chk("arb_m1_dat", m_dat_r[63:32], 32'hA5A5_0004);
        m_cyc[1] = 0; m_stb[1] = 0;
        step();

        // Bus lock: master 0 holds cyc over 4 reads with stb gaps
        m_cyc = 2'b11; m_stb = 2'b11;
        m_adr = {32'h1000_000C, 32'h1000_0010};
        for (int i = 0; i < 4; i++) begin
            step();
            m_stb[0] = 1; m_adr[31:0] = 32'h1000_0010 + 32'(4 * i);
            #1;
            chk("lock_stb", s_stb, 2'b10);
            chk("lock_adr", s_adr[63:32], 32'h1000_0010 + 32'(4 * i));
            step();
            chk("lock_ack", m_ack, 2'b01);
            m_stb[0] = 0;
            step();
            chk("lock_hold_cyc", s_cyc, 2'b10);
            chk("lock_gap_ack", m_ack, 2'b00);
        end
        m_cyc[0] = 0;
        step();
        chk("lock_release_idle", s_cyc, 2'b00);
        step();
        chk("lock_m1_adr", s_adr[63:32], 32'h1000_000C);
        chk("lock_m1_stb", s_stb, 2'b10);
        step();
        chk("lock_m1_ack", m_ack, 2'b10);
        chk("lock_m1_dat", m_dat_r[63:32], 32'hA5A5_000C);
        m_cyc = 2'b00; m_stb = 2'b00;
        step();

        // Unmapped address -> error slave
        m_cyc[0] = 1; m_stb[0] = 1; m_adr[31:0] = 32'h2000_0000;
        #1;
        chk("err_pre", m_err, 2'b00);
        step();
        chk("err_no_s_cyc", s_cyc, 2'b00);
        chk("err_not_yet", m_err, 2'b00);
        step();
        chk("err_pulse1", m_err, 2'b01);
        chk("err_no_ack", m_ack, 2'b00);
        step();
        chk("err_rest", m_err, 2'b00);
        step();
        chk("err_pulse2", m_err, 2'b01);
        m_cyc[0] = 0; m_stb[0] = 0;
        step();
        chk("err_done", m_err, 2'b00);

        // Reset mid-transfer; pointer must restart at 0
        m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 1; m_adr[31:0] = 32'h4; m_dat_w[31:0] = 32'hDEAD_BEEF;
        step();
        chk("mid_granted", s_cyc, 2'b01);
        rstn = 0;
        m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 0; m_adr[63:32] = 32'h0;
        step();
        chk("mid_rst_s_cyc", s_cyc, 2'b00);
        chk("mid_rst_ack", m_ack, 2'b00);
        chk("mid_rst_dat", m_dat_r, 64'h0);
        step();
        rstn = 1;
        step();
        chk("post_rst_stb", s_stb, 2'b01);
        chk("post_rst_m0_adr", s_adr[31:0], 32'h4);
        step();
        chk("post_rst_ack", m_ack, 2'b01);
        m_cyc[0] = 0; m_stb[0] = 0; m_we[0] = 0;
        step();
        step();
        chk("post_rst_m1_adr", s_adr[31:0], 32'h0);
        step();
        chk("post_rst_m1_ack", m_ack, 2'b10);
        chk("post_rst_m1_dat", m_dat_r[63:32], 32'h1234_5678);
        m_cyc = 2'b00; m_stb = 2'b00;
        step();

        // Hung slave 1
        hang1 = 1;
        m_cyc[0] = 1; m_stb[0] = 1; m_adr[31:0] = 32'h1000_0040;
        got = 0;
        for (int c = 1; c <= 400; c++) begin
            step();
            if (m_err[0]) begin
                got = c;
                break;
            end
        end
`ifdef WB_IC_TIMEOUT_EN
        chk("to_cycle", 64'(got), 64'd256);
        chk("to_stb_dropped", s_stb, 2'b00);
        step();
        chk("to_err_one_cycle", m_err, 2'b00);
        chk("to_stb_back", s_stb, 2'b10);
`else
        chk("no_to_err", 64'(got), 64'd0);
        chk("no_to_stalled_stb", s_stb, 2'b10);
`endif
        m_cyc = 2'b00; m_stb = 2'b00; hang1 = 0;
        step();
        chk("final_idle", s_cyc, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
